wb_ram_arbiter: RTL and testbench

//  Two-master Wishbone arbiter in front of the tagged RAM slave: m0 = instruction fetch, m1 = data/LSU.

---
 rtl/wb_ram_arbiter_if.sv | 30 +++
 rtl/wb_ram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ram_arbiter_if.sv
// Wishbone link between one master and the arbiter, or between the arbiter and
// the tagged RAM slave. Carries the request bundle plus ack/err/read data.
interface wb_ram_arbiter_if #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4
);
  logic [WB_ADDR_WIDTH-1:0] addr;
  logic [WB_DATA_WIDTH-1:0] wdata;
  logic [WB_SEL_WIDTH-1:0]  sel;
  logic                     we;
  logic                     cyc;
  logic                     stb;
  logic                     check_tags;
  logic                     ack;
  logic                     err;
  logic [WB_DATA_WIDTH-1:0] rdata;

  // Side that issues requests.
  modport master (
    output addr, wdata, sel, we, cyc, stb, check_tags,
    input  ack, err, rdata
  );

  // Side that answers requests.
  modport slave (
    input  addr, wdata, sel, we, cyc, stb, check_tags,
    output ack, err, rdata
  );
endinterface

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter in front of the tagged RAM slave.
// m0 = instruction fetch, m1 = data/LSU. One master owns the slave per
// transaction, contention is resolved round-robin, and every transaction is
// followed by a single idle GAP cycle so the slave's one-cycle STOP state is
// never overrun.
// Optional feature: define WB_ARB_TIMEOUT_EN to abort a transaction that sees
// no ack for TIMEOUT_CYCLES BUSY cycles and pulse err to the owning master.
module wb_ram_arbiter #(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_ram_arbiter_if.slave  m0,
  wb_ram_arbiter_if.slave  m1,
  wb_ram_arbiter_if.master s,
  output logic [1:0]       grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  // 1 = m1 was granted last, 0 = m0 was granted last
  logic last_grant_q, last_grant_d;

  logic m0_req, m1_req;
  logic busy;
  logic timeout_hit;
  logic pick_m1;

  // Bundle of the currently granted master
  logic [WB_ADDR_WIDTH-1:0] mux_addr;
  logic [WB_DATA_WIDTH-1:0] mux_wdata;
  logic [WB_SEL_WIDTH-1:0]  mux_sel;
  logic                     mux_we;
  logic                     mux_cyc;
  logic                     mux_req;
  logic                     mux_check_tags;

  assign m0_req  = m0.cyc & m0.stb;
  assign m1_req  = m1.cyc & m1.stb;
  assign busy    = (state_q == BUSY);
  assign grant_o = grant_q;

  // Select the granted master's request bundle (m0 unless m1 holds the grant)
  always_comb begin
    mux_addr       = m0.addr;
    mux_wdata      = m0.wdata;
    mux_sel        = m0.sel;
    mux_we         = m0.we;
    mux_cyc        = m0.cyc;
    mux_req        = m0_req;
    mux_check_tags = m0.check_tags;
    if (grant_q[1]) begin
      mux_addr       = m1.addr;
      mux_wdata      = m1.wdata;
      mux_sel        = m1.sel;
      mux_we         = m1.we;
      mux_cyc        = m1.cyc;
      mux_req        = m1_req;
      mux_check_tags = m1.check_tags;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TIMER_W-1:0] timer_q;

  assign timeout_hit = busy && (timer_q == TIMER_W'(TIMEOUT_CYCLES));

  // Count BUSY cycles without ack; held at zero outside BUSY so it starts clean
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      timer_q <= '0;
    end else if (!busy) begin
      timer_q <= '0;
    end else if (!s.ack && !timeout_hit) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Timeout error goes to the owner only, and an ack in the same cycle wins
  always_comb begin
    m0.err = busy & grant_q[0] & timeout_hit & ~s.ack;
    m1.err = busy & grant_q[1] & timeout_hit & ~s.ack;
  end
`else
  assign timeout_hit = 1'b0;

  // Without the timeout feature a transaction can never error out
  always_comb begin
    m0.err = 1'b0;
    m1.err = 1'b0;
  end
`endif

  // State, grant and round-robin history registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Arbitration and transaction sequencing: IDLE -> BUSY -> GAP -> IDLE
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pick_m1      = m1_req & (~m0_req | ~last_grant_q);
    case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        if (m0_req || m1_req) begin
          state_d      = BUSY;
          grant_d      = pick_m1 ? 2'b10 : 2'b01;
          last_grant_d = pick_m1;
        end
      end
      BUSY: begin
        if (s.ack || !mux_cyc || timeout_hit) begin
          state_d = GAP;
          grant_d = 2'b00;
        end
      end
      GAP: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Slave bundle follows the owner only while BUSY; strobes drop on timeout
  always_comb begin
    s.addr       = '0;
    s.wdata      = '0;
    s.sel        = '0;
    s.we         = 1'b0;
    s.cyc        = 1'b0;
    s.stb        = 1'b0;
    s.check_tags = 1'b0;
    if (busy) begin
      s.addr       = mux_addr;
      s.wdata      = mux_wdata;
      s.sel        = mux_sel;
      s.we         = mux_we;
      s.cyc        = mux_req & ~timeout_hit;
      s.stb        = mux_req & ~timeout_hit;
      s.check_tags = mux_check_tags;
    end
  end

  // Only the owning master sees the slave's ack and read data
  always_comb begin
    m0.ack   = busy & grant_q[0] & s.ack;
    m1.ack   = busy & grant_q[1] & s.ack;
    m0.rdata = '0;
    m1.rdata = '0;
    if (busy && grant_q[0]) begin
      m0.rdata = s.rdata;
    end
    if (busy && grant_q[1]) begin
      m1.rdata = s.rdata;
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed testbench for wb_ram_arbiter: reset, single-master read, contention
// alternation, delayed-ack write, tag write with a waiting master, async reset
// mid-transaction, abandoned cycle, ack coinciding with cyc drop, and (with
// WB_ARB_TIMEOUT_EN) the timeout abort.
module tb_wb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  int         checks = 0;
  int         errors = 0;

  wb_ram_arbiter_if m0_if ();
  wb_ram_arbiter_if m1_if ();
  wb_ram_arbiter_if s_if ();

  wb_ram_arbiter dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0       (m0_if),
    .m1       (m1_if),
    .s        (s_if),
    .grant_o  (grant)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge of the current cycle for sampling
  task automatic atSample();
    @(negedge clk);
  endtask

  // Drive one master's request bundle; req sets both cyc and stb
  task automatic applyStimulus(input int m, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] sel,
                               input logic we, input logic req, input logic tags);
    if (m == 0) begin
      m0_if.addr = addr; m0_if.wdata = wdata; m0_if.sel = sel; m0_if.we = we;
      m0_if.cyc = req; m0_if.stb = req; m0_if.check_tags = tags;
    end else begin
      m1_if.addr = addr; m1_if.wdata = wdata; m1_if.sel = sel; m1_if.we = we;
      m1_if.cyc = req; m1_if.stb = req; m1_if.check_tags = tags;
    end
  endtask

  // Drive the slave's response
  task automatic slaveRespond(input logic ack, input logic [31:0] rdata);
    s_if.ack   = ack;
    s_if.rdata = rdata;
  endtask

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    slaveRespond(1'b0, 32'h0);
    s_if.err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    atSample();
    checkOutput("rst_grant", 64'(grant), 64'h0);
    checkOutput("rst_s_cyc", 64'(s_if.cyc), 64'h0);
    checkOutput("rst_s_stb", 64'(s_if.stb), 64'h0);
    checkOutput("rst_m0_ack", 64'(m0_if.ack), 64'h0);
    checkOutput("rst_m1_ack", 64'(m1_if.ack), 64'h0);
    checkOutput("rst_m0_err", 64'(m0_if.err), 64'h0);

    // Test 1: m0 word read, one-cycle arbitration latency
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    slaveRespond(1'b0, 32'hDEADBEEF);
    atSample();
    checkOutput("t1_idle_grant", 64'(grant), 64'h0);
    checkOutput("t1_idle_s_cyc", 64'(s_if.cyc), 64'h0);
    nextCycle();
    slaveRespond(1'b1, 32'hDEADBEEF);
    atSample();
    checkOutput("t1_busy_grant", 64'(grant), 64'h1);
    checkOutput("t1_s_cyc", 64'(s_if.cyc), 64'h1);
    checkOutput("t1_s_addr", 64'(s_if.addr), 64'h100);
    checkOutput("t1_s_sel", 64'(s_if.sel), 64'hF);
    checkOutput("t1_m0_ack", 64'(m0_if.ack), 64'h1);
    checkOutput("t1_m0_rdata", 64'(m0_if.rdata), 64'hDEADBEEF);
    checkOutput("t1_m1_ack", 64'(m1_if.ack), 64'h0);
    nextCycle();
    applyStimulus(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    slaveRespond(1'b0, 32'h0);
    atSample();
    checkOutput("t1_gap_grant", 64'(grant), 64'h0);
    checkOutput("t1_gap_m0_ack", 64'(m0_if.ack), 64'h0);
    checkOutput("t1_gap_s_cyc", 64'(s_if.cyc), 64'h0);
    nextCycle();
    atSample();
    checkOutput("t1_idle2_grant", 64'(grant), 64'h0);

    // Test 2: contention after reset, m0 first then alternating
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 32'h200, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    applyStimulus(1, 32'h300, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    slaveRespond(1'b1, 32'h12345678);
    atSample();
    checkOutput("t2_idle_grant", 64'(grant), 64'h0);
    checkOutput("t2_idle_m0_ack", 64'(m0_if.ack), 64'h0);
    nextCycle();
    atSample();
    checkOutput("t2_first_grant", 64'(grant), 64'h1);
    checkOutput("t2_first_s_addr", 64'(s_if.addr), 64'h200);
    checkOutput("t2_first_m0_ack", 64'(m0_if.ack), 64'h1);
    checkOutput("t2_first_m0_rdata", 64'(m0_if.rdata), 64'h12345678);
    checkOutput("t2_first_m1_ack", 64'(m1_if.ack), 64'h0);
    checkOutput("t2_first_m1_rdata", 64'(m1_if.rdata), 64'h0);
    nextCycle();
    atSample();
    checkOutput("t2_gap1_grant", 64'(grant), 64'h0);
    checkOutput("t2_gap1_m0_ack", 64'(m0_if.ack), 64'h0);
    checkOutput("t2_gap1_s_cyc", 64'(s_if.cyc), 64'h0);
    nextCycle();
    atSample();
    checkOutput("t2_idle1_grant", 64'(grant), 64'h0);
    nextCycle();
    atSample();
    checkOutput("t2_second_grant", 64'(grant), 64'h2);
    checkOutput("t2_second_s_addr", 64'(s_if.addr), 64'h300);
    checkOutput("t2_second_m1_ack", 64'(m1_if.ack), 64'h1);
    checkOutput("t2_second_m1_rdata", 64'(m1_if.rdata), 64'h12345678);
    checkOutput("t2_second_m0_ack", 64'(m0_if.ack), 64'h0);
    checkOutput("t2_second_m0_rdata", 64'(m0_if.rdata), 64'h0);
    nextCycle();
    nextCycle();
    nextCycle();
    atSample();
    checkOutput("t2_third_grant", 64'(grant), 64'h1);
    checkOutput("t2_third_m0_ack", 64'(m0_if.ack), 64'h1);
    nextCycle();
    applyStimulus(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    slaveRespond(1'b0, 32'h0);
    atSample();
    checkOutput("t2_gap3_grant", 64'(grant), 64'h0);

    // Test 3: m1 byte write with the ack held off for two BUSY cycles
    nextCycle();
    applyStimulus(1, 32'h400, 32'hA5, 4'b0001, 1'b1, 1'b1, 1'b0);
    atSample();
    checkOutput("t3_idle_grant", 64'(grant), 64'h0);
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      atSample();
      checkOutput("t3_wait_grant", 64'(grant), 64'h2);
      checkOutput("t3_wait_s_addr", 64'(s_if.addr), 64'h400);
      checkOutput("t3_wait_s_wdata", 64'(s_if.wdata), 64'hA5);
      checkOutput("t3_wait_s_sel", 64'(s_if.sel), 64'h1);
      checkOutput("t3_wait_s_we", 64'(s_if.we), 64'h1);
      checkOutput("t3_wait_s_stb", 64'(s_if.stb), 64'h1);
      checkOutput("t3_wait_m1_ack", 64'(m1_if.ack), 64'h0);
    end
    nextCycle();
    slaveRespond(1'b1, 32'h0);
    atSample();
    checkOutput("t3_ack_m1_ack", 64'(m1_if.ack), 64'h1);
    checkOutput("t3_ack_s_wdata", 64'(s_if.wdata), 64'hA5);
    nextCycle();
    applyStimulus(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    slaveRespond(1'b0, 32'h0);
    atSample();
    checkOutput("t3_gap_grant", 64'(grant), 64'h0);
    checkOutput("t3_gap_m1_ack", 64'(m1_if.ack), 64'h0);
    checkOutput("t3_gap_s_wdata", 64'(s_if.wdata), 64'h0);

    // Test 4: m0 tag write while m1 waits for its turn
    nextCycle();
    applyStimulus(0, 32'h500, 32'h0F, 4'b0101, 1'b1, 1'b1, 1'b1);
    atSample();
    checkOutput("t4_idle_grant", 64'(grant), 64'h0);
    checkOutput("t4_idle_s_sel", 64'(s_if.sel), 64'h0);
    nextCycle();
    applyStimulus(1, 32'h600, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    atSample();
    checkOutput("t4_busy_grant", 64'(grant), 64'h1);
    checkOutput("t4_s_sel", 64'(s_if.sel), 64'h5);
    checkOutput("t4_s_check_tags", 64'(s_if.check_tags), 64'h1);
    checkOutput("t4_s_addr", 64'(s_if.addr), 64'h500);
    checkOutput("t4_m1_ack", 64'(m1_if.ack), 64'h0);
    nextCycle();
    slaveRespond(1'b1, 32'h0);
    atSample();
    checkOutput("t4_ack_m0_ack", 64'(m0_if.ack), 64'h1);
    checkOutput("t4_ack_m1_ack", 64'(m1_if.ack), 64'h0);
    checkOutput("t4_ack_grant", 64'(grant), 64'h1);
    nextCycle();
    applyStimulus(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    slaveRespond(1'b0, 32'h0);
    atSample();
    checkOutput("t4_gap_grant", 64'(grant), 64'h0);
    nextCycle();
    atSample();
    checkOutput("t4_idle2_grant", 64'(grant), 64'h0);
    nextCycle();
    atSample();
    checkOutput("t4_m1_grant", 64'(grant), 64'h2);
    checkOutput("t4_m1_s_addr", 64'(s_if.addr), 64'h600);
    checkOutput("t4_m1_s_check_tags", 64'(s_if.check_tags), 64'h0);
    checkOutput("t4_m1_s_cyc", 64'(s_if.cyc), 64'h1);

    // Test 5: asynchronous reset in the middle of the m1 transaction
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_async_s_cyc", 64'(s_if.cyc), 64'h0);
    checkOutput("t5_async_s_stb", 64'(s_if.stb), 64'h0);
    checkOutput("t5_async_grant", 64'(grant), 64'h0);
    checkOutput("t5_async_s_addr", 64'(s_if.addr), 64'h0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    slaveRespond(1'b1, 32'hCAFE);
    atSample();
    checkOutput("t5_post_m1_ack", 64'(m1_if.ack), 64'h0);
    checkOutput("t5_post_m0_ack", 64'(m0_if.ack), 64'h0);
    checkOutput("t5_post_grant", 64'(grant), 64'h0);
    nextCycle();
    atSample();
    checkOutput("t5_post2_m1_ack", 64'(m1_if.ack), 64'h0);
    nextCycle();
    slaveRespond(1'b0, 32'h0);

`ifdef WB_ARB_TIMEOUT_EN
    // Test 6: slave never acks, m0 times out and m1 follows
    nextCycle();
    applyStimulus(0, 32'h700, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    applyStimulus(1, 32'h800, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    atSample();
    checkOutput("t6_idle_grant", 64'(grant), 64'h0);
    for (int i = 1; i <= 16; i++) begin
      nextCycle();
      atSample();
      checkOutput("t6_wait_grant", 64'(grant), 64'h1);
      checkOutput("t6_wait_s_cyc", 64'(s_if.cyc), 64'h1);
      checkOutput("t6_wait_m0_err", 64'(m0_if.err), 64'h0);
    end
    nextCycle();
    atSample();
    checkOutput("t6_to_m0_err", 64'(m0_if.err), 64'h1);
    checkOutput("t6_to_m1_err", 64'(m1_if.err), 64'h0);
    checkOutput("t6_to_s_cyc", 64'(s_if.cyc), 64'h0);
    checkOutput("t6_to_m0_ack", 64'(m0_if.ack), 64'h0);
    nextCycle();
    applyStimulus(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    atSample();
    checkOutput("t6_gap_m0_err", 64'(m0_if.err), 64'h0);
    checkOutput("t6_gap_grant", 64'(grant), 64'h0);
    nextCycle();
    atSample();
    checkOutput("t6_idle2_grant", 64'(grant), 64'h0);
    nextCycle();
    slaveRespond(1'b1, 32'h0);
    atSample();
    checkOutput("t6_m1_grant", 64'(grant), 64'h2);
    checkOutput("t6_m1_ack", 64'(m1_if.ack), 64'h1);
    checkOutput("t6_m1_err", 64'(m1_if.err), 64'h0);
    nextCycle();
    applyStimulus(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    slaveRespond(1'b0, 32'h0);
    nextCycle();
`endif

    // Test 7: m0 abandons its cycle before any ack
    nextCycle();
    applyStimulus(0, 32'h900, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    atSample();
    checkOutput("t7_idle_grant", 64'(grant), 64'h0);
    nextCycle();
    atSample();
    checkOutput("t7_busy_grant", 64'(grant), 64'h1);
    checkOutput("t7_busy_s_cyc", 64'(s_if.cyc), 64'h1);
    nextCycle();
    applyStimulus(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    atSample();
    checkOutput("t7_drop_m0_ack", 64'(m0_if.ack), 64'h0);
    checkOutput("t7_drop_s_cyc", 64'(s_if.cyc), 64'h0);
    checkOutput("t7_drop_grant", 64'(grant), 64'h1);
    nextCycle();
    atSample();
    checkOutput("t7_gap_grant", 64'(grant), 64'h0);

    // Test 8: ack lands in the same cycle m1 drops cyc
    nextCycle();
    applyStimulus(1, 32'hA00, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    atSample();
    checkOutput("t8_idle_grant", 64'(grant), 64'h0);
    nextCycle();
    atSample();
    checkOutput("t8_busy_grant", 64'(grant), 64'h2);
    nextCycle();
    applyStimulus(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    slaveRespond(1'b1, 32'h5555AAAA);
    atSample();
    checkOutput("t8_m1_ack", 64'(m1_if.ack), 64'h1);
    checkOutput("t8_m1_rdata", 64'(m1_if.rdata), 64'h5555AAAA);
    checkOutput("t8_s_cyc", 64'(s_if.cyc), 64'h0);
    nextCycle();
    slaveRespond(1'b0, 32'h0);
    atSample();
    checkOutput("t8_gap_grant", 64'(grant), 64'h0);
    checkOutput("t8_gap_m1_ack", 64'(m1_if.ack), 64'h0);
    nextCycle();
    atSample();
    checkOutput("t8_idle_grant2", 64'(grant), 64'h0);
    checkOutput("t8_m0_err", 64'(m0_if.err), 64'h0);
    checkOutput("t8_m1_err", 64'(m1_if.err), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
